ent_map_arbiter: RTL and testbench
==================================

# ent_map_arbiter

Owns the 40×30 cell entity map that feeds the pixel pattern stage's 2-bit `ent` input, and shares it between two users. Users are VGA scan-out (read every pixel) and game logic (cell writes, full-map clears). Game writes are queued in a small FIFO and applied only during vertical blanking, so a frame never shows a half-updated field. The block sits between the game FSM and the pattern generator, on the VGA pixel clock.

## Interface
- `FIFO_DEPTH`, 4: write-queue entries (power of two, ≥2).
- `CLEAR_ENT`, 2'b11: entity code written by clear; also output outside the active area (`ENT_NOTHING`).
- `V_ACTIVE`, 480: first blanking row.
- `iVGA_CLK` in 1: pixel clock; the only clock.
- `reset` in 1: asynchronous, active-high.
- `iVGA_X` in 10: current pixel column, 0..799.
- `iVGA_Y` in 10: current pixel row, 0..524.
- `oEnt` out 2: entity of the cell under (`iVGA_X`,`iVGA_Y`), registered.
- `iWr_valid` in 1: game write request.
- `oWr_ready` out 1: FIFO can accept; transfer when `iWr_valid & oWr_ready` at a clock edge.
- `iWr_cx` in 6: cell column, 0..39.
- `iWr_cy` in 5: cell row, 0..29.
- `iWr_ent` in 2: entity code to store.
- `iClear` in 1: single-cycle clear request.
- `oBusy` out 1: clear in progress or FIFO non-empty.

## Operation
- Map: 1200×2-bit, linear address `cy*40 + cx` (11 bits). Reset does not initialise map contents; reset schedules a clear instead.
- Read path: cell = (`iVGA_X>>4`, `iVGA_Y>>4`).
  - If `iVGA_X<640` and `iVGA_Y<V_ACTIVE`: `oEnt` ← map[cell].
  - Otherwise `oEnt` ← `CLEAR_ENT`.
- Blank window (`blank`): `iVGA_Y >= V_ACTIVE`. This is the only time the map is written, so reads and writes never collide.
- FSM states:
  - IDLE: FIFO empty, no clear.
  - DRAIN: FIFO non-empty. On each `blank` cycle, pop one entry and write it. Entries with `cx>39` or `cy>29` are popped and discarded, with no map write. Go to IDLE when the last entry pops.
  - CLEAR: 11-bit counter `clr_addr`. On each `blank` cycle, write map[`clr_addr`] ← `CLEAR_ENT` and increment. After address 1199 is written, go to DRAIN if the FIFO is non-empty, else IDLE.
- In all states, a non-`blank` cycle makes no map write and holds the state and counters.
- `iClear` accepted in IDLE or DRAIN:
  - Enter CLEAR with `clr_addr`=0.
  - Flush all FIFO entries enqueued before that edge.
  - A write accepted on the same edge as `iClear` is kept and applied after the clear.
- `iClear` during CLEAR is ignored; the clear does not restart.
- Writes accepted during CLEAR are queued and drained after the clear completes.
- `oWr_ready` = FIFO not full, registered.
  - Push and pop on the same edge while full is not possible, since ready is low when full.
  - Push and pop on the same edge otherwise leaves the count unchanged.
- `oBusy` = (state==CLEAR) | (count!=0).

## Timing
- Reset values:
  - `oEnt`=`CLEAR_ENT`, `oWr_ready`=1, `oBusy`=1.
  - State CLEAR, `clr_addr`=0, FIFO empty.
- Reset asserted mid-clear or mid-drain discards all progress and pending writes. The clear then restarts from 0 after release.
- Read latency: 1 clock. `oEnt` at edge N+1 reflects the coordinates sampled at edge N. The sync generator compensates for the total pipeline delay (this block plus the pattern stage).
- Write visibility: an entry popped at edge N is readable from edge N+1. Since pops happen only in blanking, in practice it is first visible in the next active frame.
- Throughput:
  - One map write per blank clock.
  - A full clear takes exactly 1200 blank clocks, which fits in one 45-line blanking period (36000 clocks).
  - A full FIFO drains in `FIFO_DEPTH` blank clocks.
- Queued writes never pop during active rows, even when the FIFO is full. The game side stalls on `oWr_ready`=0.

## Test plan
- **Reset clear:** release reset at Y=0, run to frame 2, scan all cells. Required: every `oEnt` = 2'b11. `oBusy` falls exactly 1200 blank clocks after the first blank cycle.
- **Deferred write:** at Y=100, write (cx=5, cy=3, ent=1). Required: `oEnt` stays 3 for X=80..95, Y=48..63 for the rest of the frame. It reads 1 in the next frame, one clock after those coordinates are presented.
- **Backpressure:** in the active area, push 5 writes back-to-back. Required: `oWr_ready` drops after the 4th accept. The 5th is accepted only after the first blank pop. All 5 are applied in order, and the last write to a duplicated cell wins.
- **Clear vs. queue:**
  - Queue 2 writes, then assert `iClear` together with a 3rd write.
  - Required: the first 2 are lost, the map is all 3 except the 3rd write's cell, and `oBusy` stays 1 until that write pops.
- **Out of range:** write cx=45, cy=2, ent=0. Required: the entry is popped and dropped, and no map cell changes. `oEnt`=3 at X=700 and at Y=500.
- **Reset mid-drain:** assert reset with 3 entries queued. Required: FIFO empty, state CLEAR, and none of the 3 entries is applied.

Source files
------------

// File: rtl/ent_map_arbiter_if.sv
// Game-side write/clear bus of the entity map arbiter.
interface ent_map_arbiter_if;
    logic       iWr_valid;
    logic       oWr_ready;
    logic [5:0] iWr_cx;
    logic [4:0] iWr_cy;
    logic [1:0] iWr_ent;
    logic       iClear;
    logic       oBusy;

    modport master (
        output iWr_valid, iWr_cx, iWr_cy, iWr_ent, iClear,
        input  oWr_ready, oBusy
    );

    modport slave (
        input  iWr_valid, iWr_cx, iWr_cy, iWr_ent, iClear,
        output oWr_ready, oBusy
    );
endinterface

// File: rtl/ent_map_arbiter.sv
// 40x30 entity map shared between VGA scan-out reads and game writes;
// game writes are queued and applied only during vertical blanking.
//
// state | meaning
// IDLE  | write queue empty, no clear pending
// DRAIN | queue non-empty; one entry popped per blank clock
// CLEAR | sweeping clrAddr 0..1199 with CLEAR_ENT, one cell per blank clock
module ent_map_arbiter #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] CLEAR_ENT  = 2'b11,
    parameter int         V_ACTIVE   = 480
) (
    input  logic              iVGA_CLK,
    input  logic              reset,
    input  logic [9:0]        iVGA_X,
    input  logic [9:0]        iVGA_Y,
    output logic [1:0]        oEnt,
    ent_map_arbiter_if.slave  wrBus
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int MAP_CELLS = 1200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state, nextState;
    logic [1:0]        entMap [MAP_CELLS];
    logic [12:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [CNT_W-1:0]  count, nextCount;
    logic [10:0]       clrAddr;

    logic        blank, activeArea, push, pop, clearAcc, clearDone;
    logic [12:0] head;
    logic [5:0]  headCx;
    logic [4:0]  headCy;
    logic [1:0]  headEnt;
    logic        headInRange;
    logic [5:0]  xCell, yCell;
    logic [10:0] rdAddr, wrAddr;
    logic        mapWe;
    logic [10:0] mapAddr;
    logic [1:0]  mapData;

    assign blank      = (iVGA_Y >= 10'(V_ACTIVE));
    assign activeArea = (iVGA_X < 10'd640) && !blank;
    assign xCell      = iVGA_X[9:4];
    assign yCell      = iVGA_Y[9:4];
    assign rdAddr     = {5'd0, yCell} * 11'd40 + {5'd0, xCell};

    assign head        = fifoMem[rdPtr];
    assign headCx      = head[12:7];
    assign headCy      = head[6:2];
    assign headEnt     = head[1:0];
    assign headInRange = (headCx <= 6'd39) && (headCy <= 5'd29);
    assign wrAddr      = {6'd0, headCy} * 11'd40 + {5'd0, headCx};

    assign push      = wrBus.iWr_valid & wrBus.oWr_ready;
    assign clearAcc  = wrBus.iClear & (state != CLEAR);
    // A clear wins over a pop on the same edge; the popped cell is swept anyway.
    assign pop       = (state == DRAIN) & blank & (count != '0) & !clearAcc;
    assign clearDone = (state == CLEAR) & blank & (clrAddr == 11'(MAP_CELLS - 1));

    assign wrBus.oBusy = (state == CLEAR) | (count != '0);

    always_comb begin
        mapWe   = 1'b0;
        mapAddr = '0;
        mapData = CLEAR_ENT;
        if (state == CLEAR && blank) begin
            mapWe   = 1'b1;
            mapAddr = clrAddr;
        end else if (pop && headInRange) begin
            mapWe   = 1'b1;
            mapAddr = wrAddr;
            mapData = headEnt;
        end
    end

    // A write accepted on the clear edge survives; everything older is flushed.
    always_comb begin
        if (clearAcc) begin
            nextCount = push ? CNT_W'(1) : '0;
        end else begin
            nextCount = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DRAIN: begin
                if (clearAcc) begin
                    nextState = CLEAR;
                end else begin
                    nextState = (nextCount != '0) ? DRAIN : IDLE;
                end
            end
            CLEAR: begin
                if (clearDone) begin
                    nextState = (nextCount != '0) ? DRAIN : IDLE;
                end
            end
            default: nextState = CLEAR;
        endcase
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state           <= CLEAR;
            clrAddr         <= '0;
            rdPtr           <= '0;
            wrPtr           <= '0;
            count           <= '0;
            wrBus.oWr_ready <= 1'b1;
            oEnt            <= CLEAR_ENT;
        end else begin
            state           <= nextState;
            count           <= nextCount;
            wrBus.oWr_ready <= (nextCount != CNT_W'(FIFO_DEPTH));
            if (clearAcc) begin
                clrAddr <= '0;
            end else if (state == CLEAR && blank) begin
                clrAddr <= clrAddr + 11'd1;
            end
            if (clearAcc) begin
                rdPtr <= wrPtr;
            end else if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            oEnt <= activeArea ? entMap[rdAddr] : CLEAR_ENT;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (push) begin
            fifoMem[wrPtr] <= {wrBus.iWr_cx, wrBus.iWr_cy, wrBus.iWr_ent};
        end
        if (mapWe) begin
            entMap[mapAddr] <= mapData;
        end
    end
endmodule

// File: tb/tb_ent_map_arbiter.sv
// Directed bench for ent_map_arbiter: read-vector table plus hand-written
// sequences for the reset clear, backpressure, clear/queue and reset cases.
module tb_ent_map_arbiter;
    logic       iVGA_CLK;
    logic       reset;
    logic [9:0] vgaX, vgaY;
    logic [1:0] ent;

    ent_map_arbiter_if wrBus();

    ent_map_arbiter dut (
        .iVGA_CLK (iVGA_CLK),
        .reset    (reset),
        .iVGA_X   (vgaX),
        .iVGA_Y   (vgaY),
        .oEnt     (ent),
        .wrBus    (wrBus)
    );

    typedef struct {
        int phase;
        int x;
        int y;
        int exp;
    } rdVec_t;

    rdVec_t vecs[$];
    int     nTests = 0;
    int     nFail  = 0;

    initial iVGA_CLK = 1'b0;
    always #5 iVGA_CLK = ~iVGA_CLK;

    task automatic tick();
        @(posedge iVGA_CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic void addVec(input int p, input int x, input int y, input int e);
        rdVec_t v;
        v.phase = p;
        v.x     = x;
        v.y     = y;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    task automatic runPhase(input int p);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == p) begin
                vgaX = 10'(vecs[i].x);
                vgaY = 10'(vecs[i].y);
                tick();
                check($sformatf("read p%0d (%0d,%0d)", p, vecs[i].x, vecs[i].y),
                      32'(ent), 32'(vecs[i].exp));
            end
        end
        vgaX = 10'd0;
        vgaY = 10'd100;
    endtask

    task automatic pushWrite(input string nm, input int cx, input int cy, input int e);
        logic rb;
        wrBus.iWr_valid = 1'b1;
        wrBus.iWr_cx    = 6'(cx);
        wrBus.iWr_cy    = 5'(cy);
        wrBus.iWr_ent   = 2'(e);
        rb = wrBus.oWr_ready;
        tick();
        check({nm, " accepted"}, 32'(rb), 32'd1);
        wrBus.iWr_valid = 1'b0;
    endtask

    task automatic blankClear(input string nm, input int doneAt);
        vgaY = 10'd480;
        for (int i = 1; i <= doneAt; i++) begin
            tick();
            if (i == doneAt - 1) check({nm, " busy before end"}, 32'(wrBus.oBusy), 32'd1);
            if (i == doneAt)     check({nm, " busy at end"}, 32'(wrBus.oBusy), 32'd0);
        end
        vgaY = 10'd100;
    endtask

    initial begin
        logic rb;
        int   acceptEdge;

        addVec(1, 80, 48, 3);   addVec(1, 95, 63, 3);   addVec(1, 88, 56, 3);
        addVec(2, 80, 48, 1);   addVec(2, 95, 63, 1);   addVec(2, 88, 56, 1);
        addVec(2, 96, 48, 3);   addVec(2, 79, 63, 3);   addVec(2, 80, 64, 3);
        addVec(2, 700, 50, 3);
        addVec(3, 0, 0, 0);     addVec(3, 16, 0, 2);    addVec(3, 32, 0, 1);
        addVec(3, 639, 479, 2); addVec(3, 48, 0, 3);    addVec(3, 0, 480, 3);
        addVec(3, 640, 0, 3);
        addVec(4, 160, 160, 3); addVec(4, 176, 160, 3); addVec(4, 192, 160, 1);
        addVec(4, 80, 48, 3);   addVec(4, 0, 0, 3);     addVec(4, 639, 479, 3);
        addVec(5, 80, 48, 3);   addVec(5, 624, 32, 3);  addVec(5, 700, 100, 3);
        addVec(5, 100, 500, 3); addVec(5, 192, 160, 1);
        addVec(6, 16, 16, 3);   addVec(6, 32, 16, 3);   addVec(6, 48, 16, 3);
        addVec(6, 192, 160, 3);

        reset           = 1'b1;
        vgaX            = 10'd0;
        vgaY            = 10'd0;
        wrBus.iWr_valid = 1'b0;
        wrBus.iWr_cx    = '0;
        wrBus.iWr_cy    = '0;
        wrBus.iWr_ent   = '0;
        wrBus.iClear    = 1'b0;
        repeat (3) tick();
        check("reset oEnt", 32'(ent), 32'd3);
        check("reset ready", 32'(wrBus.oWr_ready), 32'd1);
        check("reset busy", 32'(wrBus.oBusy), 32'd1);

        reset = 1'b0;
        repeat (5) tick();
        check("clear holds in active rows", 32'(wrBus.oBusy), 32'd1);
        blankClear("reset clear", 1200);

        for (int cy = 0; cy < 30; cy++) begin
            for (int cx = 0; cx < 40; cx++) begin
                vgaX = 10'(cx * 16 + 5);
                vgaY = 10'(cy * 16 + 9);
                tick();
                check($sformatf("scan (%0d,%0d)", cx, cy), 32'(ent), 32'd3);
            end
        end

        // Deferred write: stays invisible until a blank pop.
        vgaX = 10'd0;
        vgaY = 10'd100;
        pushWrite("deferred", 5, 3, 1);
        check("deferred busy queued", 32'(wrBus.oBusy), 32'd1);
        runPhase(1);
        vgaY = 10'd480;
        tick();
        check("deferred busy after pop", 32'(wrBus.oBusy), 32'd0);
        runPhase(2);

        // Backpressure: four fill the queue, fifth waits for the first blank pop.
        pushWrite("bp w0", 0, 0, 1);
        pushWrite("bp w1", 1, 0, 2);
        pushWrite("bp w2", 0, 0, 0);
        check("bp ready after 3", 32'(wrBus.oWr_ready), 32'd1);
        pushWrite("bp w3", 2, 0, 1);
        check("bp ready after 4", 32'(wrBus.oWr_ready), 32'd0);
        wrBus.iWr_valid = 1'b1;
        wrBus.iWr_cx    = 6'd39;
        wrBus.iWr_cy    = 5'd29;
        wrBus.iWr_ent   = 2'd2;
        repeat (5) tick();
        check("bp ready held in active", 32'(wrBus.oWr_ready), 32'd0);
        vgaY       = 10'd480;
        acceptEdge = -1;
        for (int i = 0; i < 10; i++) begin
            rb = wrBus.oWr_ready;
            tick();
            if (rb && wrBus.iWr_valid) begin
                acceptEdge      = i;
                wrBus.iWr_valid = 1'b0;
            end
        end
        check("bp 5th accept edge", 32'(acceptEdge), 32'd1);
        check("bp drained", 32'(wrBus.oBusy), 32'd0);
        vgaY = 10'd100;
        runPhase(3);

        // Clear with queued writes; a mid-clear request must not restart it.
        pushWrite("cq A", 10, 10, 1);
        pushWrite("cq B", 11, 10, 2);
        wrBus.iWr_valid = 1'b1;
        wrBus.iWr_cx    = 6'd12;
        wrBus.iWr_cy    = 5'd10;
        wrBus.iWr_ent   = 2'd1;
        wrBus.iClear    = 1'b1;
        rb = wrBus.oWr_ready;
        tick();
        check("cq C accepted", 32'(rb), 32'd1);
        wrBus.iWr_valid = 1'b0;
        wrBus.iClear    = 1'b0;
        check("cq busy", 32'(wrBus.oBusy), 32'd1);
        vgaY = 10'd480;
        for (int i = 1; i <= 1201; i++) begin
            wrBus.iClear = (i == 600);
            tick();
            if (i == 1200) check("cq busy until C pops", 32'(wrBus.oBusy), 32'd1);
            if (i == 1201) check("cq busy after C pops", 32'(wrBus.oBusy), 32'd0);
        end
        wrBus.iClear = 1'b0;
        vgaY = 10'd100;
        runPhase(4);

        // Out-of-range entry: cx=45,cy=2 would alias cell (5,3) if written.
        pushWrite("oor", 45, 2, 0);
        check("oor busy queued", 32'(wrBus.oBusy), 32'd1);
        vgaY = 10'd480;
        tick();
        check("oor busy after pop", 32'(wrBus.oBusy), 32'd0);
        runPhase(5);

        // Reset with entries queued.
        pushWrite("rst e0", 1, 1, 0);
        pushWrite("rst e1", 2, 1, 0);
        pushWrite("rst e2", 3, 1, 0);
        vgaX = 10'd192;
        vgaY = 10'd160;
        tick();
        check("rst pre oEnt", 32'(ent), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst async oEnt", 32'(ent), 32'd3);
        check("rst async ready", 32'(wrBus.oWr_ready), 32'd1);
        check("rst async busy", 32'(wrBus.oBusy), 32'd1);
        tick();
        tick();
        vgaX  = 10'd0;
        vgaY  = 10'd0;
        reset = 1'b0;
        repeat (3) tick();
        check("rst clear holds", 32'(wrBus.oBusy), 32'd1);
        blankClear("rst clear", 1200);
        runPhase(6);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
